// File: rtl/utf8_decoder.sv
// utf8_decoder: streaming UTF-8 byte to code point decoder; define UTF8_DEC_STRICT_EN for strict lead/overlong/surrogate/range checks
module utf8_decoder #(
   parameter logic [20:0] REPLACE_CP = 21'h00FFFD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   output logic [20:0] out_cp,
   output logic        out_err,
   output logic [2:0]  out_err_code,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);
`ifdef UTF8_DEC_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, CONT, REPLAY} state_t;
   state_t state, nxt_state;
   logic [1:0] cnt, nxt_cnt;
   logic [14:0] payload, nxt_payload;
   logic [20:0] shifted, cp;
   logic [7:0] rbyte, src;
   logic [2:0] chk, nxt_chk, code, bad2;
   logic flush_pend, out_free, acc, go, emit, do_flush;
   assign out_free = ~out_valid | out_ready;
   assign in_ready = out_free & (state != REPLAY) & ~(flush_pend & (state == CONT));
   assign acc = in_valid & in_ready;
   assign busy = state == CONT;
   assign src = (state == REPLAY) ? rbyte : in_data;
   assign go = (state == REPLAY) ? out_free : acc;
   assign do_flush = (state == CONT) & out_free & (flush_pend | (flush & ~acc));
   assign shifted = {payload, src[5:0]};
   assign bad2 = (chk == 3'd1 && src < 8'hA0) ? 3'd4 :
                 (chk == 3'd2 && src > 8'h9F) ? 3'd5 :
                 (chk == 3'd3 && src < 8'h90) ? 3'd4 :
                 (chk == 3'd4 && src > 8'h8F) ? 3'd6 : 3'd0;
   // Decode the current byte against the collected sequence context
   always_comb begin
      nxt_state = IDLE;
      nxt_cnt = 2'd0;
      nxt_payload = 15'd0;
      nxt_chk = 3'd0;
      emit = 1'b1;
      cp = REPLACE_CP;
      code = 3'd0;
      if (state == CONT) begin
         if (src[7:6] != 2'b10) begin
            code = 3'd3;
            nxt_state = REPLAY;
         end else if (bad2 != 3'd0) begin
            code = bad2;
            nxt_state = REPLAY;
         end else begin
            emit = cnt == 2'd1;
            cp = shifted;
            nxt_cnt = cnt - 2'd1;
            nxt_payload = shifted[14:0];
            nxt_state = (cnt == 2'd1) ? IDLE : CONT;
         end
      end else if (!src[7]) begin
         cp = {13'd0, src};
      end else if (src[7:6] == 2'b10) begin
         code = 3'd1;
      end else if (src[7:5] == 3'b110 && (!STRICT || src[4:1] != 4'd0)) begin
         emit = 1'b0;
         nxt_state = CONT;
         nxt_cnt = 2'd1;
         nxt_payload = {10'd0, src[4:0]};
      end else if (src[7:4] == 4'b1110) begin
         emit = 1'b0;
         nxt_state = CONT;
         nxt_cnt = 2'd2;
         nxt_payload = {11'd0, src[3:0]};
         nxt_chk = !STRICT ? 3'd0 : (src == 8'hE0) ? 3'd1 : (src == 8'hED) ? 3'd2 : 3'd0;
      end else if (src[7:3] == 5'b11110 && (!STRICT || src <= 8'hF4)) begin
         emit = 1'b0;
         nxt_state = CONT;
         nxt_cnt = 2'd3;
         nxt_payload = {12'd0, src[2:0]};
         nxt_chk = !STRICT ? 3'd0 : (src == 8'hF0) ? 3'd3 : (src == 8'hF4) ? 3'd4 : 3'd0;
      end else begin
         code = 3'd2;
      end
   end
   // Sequence state, replay/flush bookkeeping and the single-entry output word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 2'd0;
         payload <= 15'd0;
         chk <= 3'd0;
         rbyte <= 8'd0;
         flush_pend <= 1'b0;
         out_valid <= 1'b0;
         out_cp <= 21'd0;
         out_err <= 1'b0;
         out_err_code <= 3'd0;
      end else begin
         flush_pend <= (flush & acc) | ((state == CONT) & flush & ~do_flush) |
                       (flush_pend & (state != IDLE) & ~do_flush);
         if (do_flush) begin
            state <= IDLE;
            cnt <= 2'd0;
            payload <= 15'd0;
            chk <= 3'd0;
         end else if (go) begin
            state <= nxt_state;
            cnt <= nxt_cnt;
            payload <= nxt_payload;
            chk <= nxt_chk;
            if (nxt_state == REPLAY) rbyte <= src;
         end
         if (do_flush || (go && emit)) begin
            out_valid <= 1'b1;
            out_cp <= do_flush ? REPLACE_CP : cp;
            out_err <= do_flush || code != 3'd0;
            out_err_code <= do_flush ? 3'd3 : code;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/utf8_decoder.md
UTF8_DECODER -- requirements
Module: utf8_decoder

Interface
REQ-001 Parameter REPLACE_CP, default 21'h00FFFD, code point emitted on every error.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_data  in  8  UTF-8 byte.
REQ-005 in_valid  in  1  in_data valid.
REQ-006 in_ready  out  1  byte accepted when in_valid & in_ready at clk edge.
REQ-007 flush  in  1  end-of-stream pulse; terminates any partial sequence.
REQ-008 out_cp  out  21  decoded code point.
REQ-009 out_err  out  1  out_cp is REPLACE_CP due to error.
REQ-010 out_err_code  out  3  0 none, 1 stray continuation, 2 invalid lead, 3 truncated, 4 overlong, 5 surrogate, 6 out of range.
REQ-011 out_valid  out  1  output word valid.
REQ-012 out_ready  in  1  output consumed when out_valid & out_ready at clk edge.
REQ-013 busy  out  1  high while a multi-byte sequence is partially collected.

Function
REQ-014 States: IDLE, CONT (1-3 continuation bytes remaining, 2-bit counter), REPLAY (one held byte reprocessed as new input).
REQ-015 Single-entry registered output; in_ready = (~out_valid | out_ready) & (state != REPLAY); full 1 byte/cycle throughput.
REQ-016 Output valid the cycle after the final byte of a sequence (or the erroring byte) is accepted; out_* stable while out_valid & ~out_ready.
REQ-017 IDLE: 00-7F emits code point directly; C2-DF / E0-EF / F0-F4 load payload bits, set remaining count 1/2/3, go CONT.
REQ-018 IDLE: 80-BF emits REPLACE_CP, code 1; C0, C1, F5-FF emit REPLACE_CP, code 2; state stays IDLE.
REQ-019 CONT: 80-BF shifts in 6 bits, decrements count; at zero emits assembled code point, goes IDLE.
REQ-020 CONT: non-continuation byte emits REPLACE_CP, code 3; byte captured into replay register, go REPLAY.
REQ-021 REPLAY: replay byte decoded exactly as in IDLE/CONT from a fresh IDLE, in_ready low for that cycle; at most one replay cycle per byte.
REQ-022 Second-byte checks (in CONT, first continuation): E0 needs A0-BF (else code 4), ED needs 80-9F (else code 5), F0 needs 90-BF (else code 4), F4 needs 80-8F (else code 6); failing byte emits REPLACE_CP with that code and is replayed.
REQ-023 flush in CONT emits REPLACE_CP code 3, goes IDLE; flush in IDLE/REPLAY ignored; flush with simultaneous accepted byte: byte handled first, flush applies to resulting state next cycle.
REQ-024 Internal events requiring emission while output is full stall (in_ready low, flush held pending in a 1-bit flag) until output drains; no output is ever dropped.
REQ-025 busy = (state == CONT).

Reset
REQ-026 rst asserted: state IDLE, counter 0, payload 0, replay register 0, flush flag 0.
REQ-027 rst asserted: out_valid 0, out_cp 0, out_err 0, out_err_code 0, busy 0; in_ready 1 from first edge after rst deasserts.
REQ-028 Reset mid-sequence discards partial payload silently; no error emitted.

Configuration
REQ-029 Macro UTF8_DEC_STRICT_EN defined: REQ-018 lead rules and REQ-022 checks active as written.
REQ-030 UTF8_DEC_STRICT_EN undefined: C0/C1 accepted as 2-byte leads, F5-F7 as 4-byte leads (result up to 1FFFFF), REQ-022 checks removed, codes 4-6 never emitted; F8-FF remain code 2.

Verification
REQ-031 Bytes 41 -> one output cp 000041, err 0, one cycle after acceptance.
REQ-032 E2 82 AC then F0 9F 98 80 back-to-back -> cp 0020AC then 01F600, err 0, busy high between lead and final byte.
REQ-033 C3 41 -> cp 00FFFD code 3, then cp 000041 err 0; in_ready low one cycle (REPLAY).
REQ-034 Strict: ED A0 80 -> FFFD code 5, FFFD code 1, FFFD code 1; non-strict build: single cp 00D800 err 0.
REQ-035 E2 82 then flush -> FFFD code 3, busy drops; out_ready held low 5 cycles during 41 42 -> first word held stable, in_ready low, no loss.
REQ-036 rst pulse after E2 82 -> no output, then 41 -> cp 000041 err 0.
